// File: rtl/scc_pkg.sv
// Shared types and constants for the SCC wave-table RAM scheduler.
// The frame is CH_NUM channel-fetch phases followed by one CPU phase.
package scc_pkg;

    localparam int CH_NUM     = 5;
    localparam int TABLE_SIZE = 32;
    localparam int RAM_AW     = 8;

    localparam logic [7:0] SCC_TABLE3_BASE = 8'h60;
    localparam logic [7:0] WAVE_RAM_TOP    = 8'd160;
    localparam logic [7:0] CPU_BAD_RDATA   = 8'hFF;
    localparam logic [7:0] SCC_T4_LO       = 8'h80;
    localparam logic [7:0] SCC_T4_HI       = 8'h9F;
    localparam logic [7:0] SCC_T4_OFS      = 8'h20;

    typedef enum logic [2:0] {
        PH_CH0 = 3'd0,
        PH_CH1 = 3'd1,
        PH_CH2 = 3'd2,
        PH_CH3 = 3'd3,
        PH_CH4 = 3'd4,
        PH_CPU = 3'd5
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        if (p == PH_CPU) begin
            return PH_CH0;
        end
        return phase_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/scc_wave_addr_map.sv
// Mode-dependent wave RAM address mapping for channel fetches and CPU accesses.
// In SCC mode channel 4 plays table 3, and CPU table 4 is read-only mirror of table 3.
module scc_wave_addr_map
    import scc_pkg::*;
(
    input  logic       scc_plus,
    input  logic [2:0] ch_idx,
    input  logic [4:0] ch_ptr,
    input  logic [7:0] cpu_addr,
    output logic [7:0] ch_addr,
    output logic [7:0] cpu_ram_addr,
    output logic       cpu_oor,
    output logic       cpu_wr_discard
);

    logic [7:0] ch_base;
    logic       cpu_in_t4;

    always_comb begin
        ch_base = {ch_idx, 5'b00000};
        if ((ch_idx == 3'd4) && !scc_plus) begin
            ch_base = SCC_TABLE3_BASE;
        end
        ch_addr = ch_base + {3'b000, ch_ptr};

        cpu_oor        = (cpu_addr >= WAVE_RAM_TOP);
        cpu_in_t4      = !scc_plus && (cpu_addr >= SCC_T4_LO) && (cpu_addr <= SCC_T4_HI);
        cpu_wr_discard = cpu_oor || cpu_in_t4;
        cpu_ram_addr   = cpu_in_t4 ? (cpu_addr - SCC_T4_OFS) : cpu_addr;
    end

endmodule

// File: rtl/scc_wave_ram_scheduler.sv
// Time-slot scheduler sharing one synchronous single-port wave RAM between five tone
// channels (phases 0-4) and one CPU access per frame (phase 5).
module scc_wave_ram_scheduler
    import scc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              scc_plus,
    input  logic [4:0]        ch_enable,
    input  logic [24:0]       ch_ptr,
    output logic [39:0]       ch_wave,
    output logic [4:0]        ch_valid,
    output logic              frame_tick,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    phase_t phase_q, phase_d;

    logic [CH_NUM-1:0][7:0] ch_wave_q, ch_wave_d;
    logic [CH_NUM-1:0]      ch_valid_q, ch_valid_d;

    logic       fetch_vld_q, fetch_vld_d;
    logic       fetch_en_q, fetch_en_d;
    logic [2:0] fetch_idx_q, fetch_idx_d;

    logic       cpu_pend_q, cpu_pend_d;
    logic       cpu_rd_q, cpu_rd_d;
    logic       cpu_bad_q, cpu_bad_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;

    logic [4:0][4:0] ptr_arr;
    logic [2:0]      ch_idx;
    logic            ch_phase;
    logic            ch_en_sel;
    logic [7:0]      ch_addr;
    logic [7:0]      cpu_ram_addr;
    logic            cpu_oor;
    logic            cpu_wr_discard;

    assign ptr_arr   = ch_ptr;
    assign ch_phase  = (phase_q != PH_CPU);
    assign ch_idx    = ch_phase ? phase_q : 3'd0;
    assign ch_en_sel = ch_phase && ch_enable[ch_idx];

    scc_wave_addr_map u_addr_map (
        .scc_plus       (scc_plus),
        .ch_idx         (ch_idx),
        .ch_ptr         (ptr_arr[ch_idx]),
        .cpu_addr       (cpu_addr),
        .ch_addr        (ch_addr),
        .cpu_ram_addr   (cpu_ram_addr),
        .cpu_oor        (cpu_oor),
        .cpu_wr_discard (cpu_wr_discard)
    );

    // RAM port: idle slots and discarded accesses leave address at 0 with no write.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (!reset) begin
            if (ch_phase) begin
                if (ch_en_sel) begin
                    ram_addr = ch_addr;
                end
            end else if (cpu_req) begin
                if (cpu_we) begin
                    if (!cpu_wr_discard) begin
                        ram_addr  = cpu_addr;
                        ram_we    = 1'b1;
                        ram_wdata = cpu_wdata;
                    end
                end else if (!cpu_oor) begin
                    ram_addr = cpu_ram_addr;
                end
            end
        end
    end

    always_comb begin
        phase_d = next_phase(phase_q);

        fetch_vld_d = ch_phase;
        fetch_en_d  = ch_en_sel;
        fetch_idx_d = ch_idx;

        ch_wave_d  = ch_wave_q;
        ch_valid_d = '0;
        if (fetch_vld_q) begin
            ch_wave_d[fetch_idx_q]  = fetch_en_q ? ram_rdata : 8'h00;
            ch_valid_d[fetch_idx_q] = 1'b1;
        end

        cpu_pend_d  = 1'b0;
        cpu_rd_d    = cpu_rd_q;
        cpu_bad_d   = cpu_bad_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        // Completion of the access issued in the previous phase-5 slot.
        if (cpu_pend_q) begin
            cpu_ack_d = 1'b1;
            if (cpu_rd_q) begin
                cpu_rdata_d = cpu_bad_q ? CPU_BAD_RDATA : ram_rdata;
            end
        end
        if (!ch_phase && cpu_req) begin
            cpu_pend_d = 1'b1;
            cpu_rd_d   = !cpu_we;
            cpu_bad_d  = cpu_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_CH0;
            ch_wave_q   <= '0;
            ch_valid_q  <= '0;
            fetch_vld_q <= 1'b0;
            fetch_en_q  <= 1'b0;
            fetch_idx_q <= 3'd0;
            cpu_pend_q  <= 1'b0;
            cpu_rd_q    <= 1'b0;
            cpu_bad_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
        end else begin
            phase_q     <= phase_d;
            ch_wave_q   <= ch_wave_d;
            ch_valid_q  <= ch_valid_d;
            fetch_vld_q <= fetch_vld_d;
            fetch_en_q  <= fetch_en_d;
            fetch_idx_q <= fetch_idx_d;
            cpu_pend_q  <= cpu_pend_d;
            cpu_rd_q    <= cpu_rd_d;
            cpu_bad_q   <= cpu_bad_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign ch_wave    = ch_wave_q;
    assign ch_valid   = ch_valid_q;
    assign frame_tick = !reset && (phase_q == PH_CPU);
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_scc_wave_ram_scheduler.sv
// Directed bench for scc_wave_ram_scheduler with a synchronous RAM model and
// scoreboards for channel samples and CPU completions.
module tb_scc_wave_ram_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scc_plus = 1'b1;
    logic [4:0]  ch_enable = 5'b11111;
    logic [24:0] ch_ptr = '0;
    logic [39:0] ch_wave;
    logic [4:0]  ch_valid;
    logic        frame_tick;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_addr = 8'h00;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    always #5 clk = ~clk;

    scc_wave_ram_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .scc_plus   (scc_plus),
        .ch_enable  (ch_enable),
        .ch_ptr     (ch_ptr),
        .ch_wave    (ch_wave),
        .ch_valid   (ch_valid),
        .frame_tick (frame_tick),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int tb_phase = 0;
    always @(posedge clk) begin
        tb_phase <= reset ? 0 : ((tb_phase == 5) ? 0 : tb_phase + 1);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ch_base(input int ch, input logic plus);
        if (ch == 4 && !plus) return 8'h60;
        return 8'(32 * ch);
    endfunction

    typedef struct { int due; int ch; logic [7:0] val; } ch_exp_t;
    typedef struct { int due; logic rd; logic [7:0] data; } cpu_exp_t;
    ch_exp_t  ch_q[$];
    cpu_exp_t cpu_q[$];

    int         cyc = 0;
    logic [7:0] exp_rdata = 8'h00;
    logic [4:0] m_ev;
    logic       m_eack;
    logic [7:0] m_a;
    logic       m_en;
    logic       m_oor;
    logic       m_t4;
    ch_exp_t    m_ce;
    cpu_exp_t   m_pe;

    // Scoreboard: expectations pushed at the issuing phase, popped when the DUT responds.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            ch_q.delete();
            cpu_q.delete();
            exp_rdata = 8'h00;
        end else begin
            check({63'b0, frame_tick}, {63'b0, tb_phase == 5}, "frame_tick");

            m_ev = 5'b0;
            if (ch_q.size() > 0 && ch_q[0].due == cyc) begin
                m_ce = ch_q.pop_front();
                m_ev[m_ce.ch] = 1'b1;
                check({56'b0, ch_wave[8*m_ce.ch +: 8]}, {56'b0, m_ce.val}, "ch_wave");
            end
            check({59'b0, ch_valid}, {59'b0, m_ev}, "ch_valid");

            m_eack = 1'b0;
            if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                m_pe = cpu_q.pop_front();
                m_eack = 1'b1;
                if (m_pe.rd) exp_rdata = m_pe.data;
            end
            check({63'b0, cpu_ack}, {63'b0, m_eack}, "cpu_ack");
            check({56'b0, cpu_rdata}, {56'b0, exp_rdata}, "cpu_rdata");

            if (tb_phase < 5) begin
                m_en = ch_enable[tb_phase];
                m_a  = ch_base(tb_phase, scc_plus) + {3'b0, ch_ptr[5*tb_phase +: 5]};
                check({56'b0, ram_addr}, {56'b0, m_en ? m_a : 8'h00}, "fetch_addr");
                check({63'b0, ram_we}, 64'd0, "fetch_we");
                m_ce.due = cyc + 2;
                m_ce.ch  = tb_phase;
                m_ce.val = m_en ? shadow[m_a] : 8'h00;
                ch_q.push_back(m_ce);
            end else if (cpu_req) begin
                m_oor = (cpu_addr >= 8'd160);
                m_t4  = !scc_plus && cpu_addr >= 8'h80 && cpu_addr <= 8'h9F;
                m_pe.due = cyc + 2;
                m_pe.rd  = !cpu_we;
                m_pe.data = 8'h00;
                if (cpu_we) begin
                    if (!m_oor && !m_t4) begin
                        check({63'b0, ram_we}, 64'd1, "cpu_wr_we");
                        check({56'b0, ram_addr}, {56'b0, cpu_addr}, "cpu_wr_addr");
                        check({56'b0, ram_wdata}, {56'b0, cpu_wdata}, "cpu_wr_data");
                        shadow[cpu_addr] = cpu_wdata;
                    end else begin
                        check({63'b0, ram_we}, 64'd0, "cpu_wr_discard");
                    end
                end else begin
                    check({63'b0, ram_we}, 64'd0, "cpu_rd_we");
                    m_a = m_t4 ? cpu_addr - 8'h20 : cpu_addr;
                    if (!m_oor) check({56'b0, ram_addr}, {56'b0, m_a}, "cpu_rd_addr");
                    m_pe.data = m_oor ? 8'hFF : shadow[m_a];
                end
                cpu_q.push_back(m_pe);
            end else begin
                check({63'b0, ram_we}, 64'd0, "idle_we");
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (tb_phase != p && n < 12) begin
            tick(1);
            n++;
        end
    endtask

    task automatic cpu_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                              output int ack_cyc);
        int n = 0;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_req   = 1'b1;
        do begin
            tick(1);
            n++;
        end while (!cpu_ack && n < 20);
        cpu_req = 1'b0;
        ack_cyc = cyc;
        check({63'b0, cpu_ack}, 64'd1, "ack_wait");
        check(64'(tb_phase), 64'd1, "ack_phase");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int c1, c2;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i);
            shadow[i] = 8'(i);
        end

        // Power-on reset
        tick(3);
        check({24'b0, ch_wave}, 64'd0, "rst_ch_wave");
        check({59'b0, ch_valid}, 64'd0, "rst_ch_valid");
        check({63'b0, cpu_ack}, 64'd0, "rst_cpu_ack");
        check({56'b0, cpu_rdata}, 64'd0, "rst_cpu_rdata");
        check({63'b0, ram_we}, 64'd0, "rst_ram_we");
        check({63'b0, frame_tick}, 64'd0, "rst_frame_tick");
        reset = 1'b0;
        tick(8);

        // 1: reset during phase 5 with a pending CPU request
        wait_phase(4);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h10;
        tick(1);
        reset = 1'b1;
        tick(1);
        check({24'b0, ch_wave}, 64'd0, "mid_rst_ch_wave");
        check({59'b0, ch_valid}, 64'd0, "mid_rst_ch_valid");
        check({63'b0, cpu_ack}, 64'd0, "mid_rst_cpu_ack");
        check({63'b0, frame_tick}, 64'd0, "mid_rst_frame_tick");
        cpu_req = 1'b0;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check({63'b0, cpu_ack}, 64'd0, "dropped_no_ack");
            tick(1);
        end

        // 2: SCC+ mode, all pointers 3
        scc_plus  = 1'b1;
        ch_enable = 5'b11111;
        ch_ptr    = {5{5'd3}};
        tick(14);
        check({24'b0, ch_wave}, {24'b0, 40'h83_63_43_23_03}, "plus_ptr3");

        // 3: SCC mode, ch4 mirrors table 3; CPU table 4 is read-only mirror
        scc_plus = 1'b0;
        ch_ptr   = {5'd5, 5'd3, 5'd3, 5'd3, 5'd3};
        tick(14);
        wait_phase(4);
        check({56'b0, ram_addr}, 64'h65, "scc_ch4_addr");
        check({56'b0, ch_wave[39:32]}, 64'h65, "scc_ch4_wave");
        cpu_access(1'b1, 8'h85, 8'h7F, c1);
        cpu_access(1'b0, 8'h85, 8'h00, c1);
        check({56'b0, cpu_rdata}, 64'h65, "scc_t4_read");
        check({56'b0, mem[8'h85]}, 64'h85, "scc_t4_wr_dropped");
        check({56'b0, mem[8'h65]}, 64'h65, "scc_t3_intact");

        // 4: write then back-to-back read, visible to channel 0
        scc_plus = 1'b1;
        cpu_access(1'b1, 8'h10, 8'h80, c1);
        cpu_access(1'b0, 8'h10, 8'h00, c2);
        check(64'(c2 - c1), 64'd6, "b2b_ack_spacing");
        check({56'b0, cpu_rdata}, 64'h80, "wr_rd_data");
        ch_ptr[4:0] = 5'd16;
        tick(12);
        check({56'b0, ch_wave[7:0]}, 64'h80, "ch0_sees_write");

        // 5: out-of-range CPU accesses
        cpu_access(1'b0, 8'hA0, 8'h00, c1);
        check({56'b0, cpu_rdata}, 64'hFF, "oor_read");
        cpu_access(1'b1, 8'hA5, 8'h11, c1);
        check({56'b0, mem[8'hA5]}, 64'hA5, "oor_wr_dropped");
        check({56'b0, cpu_rdata}, 64'hFF, "wr_keeps_rdata");

        // 6: partial channel enable
        ch_enable = 5'b10101;
        ch_ptr    = {5{5'd7}};
        tick(14);
        check({56'b0, ch_wave[15:8]}, 64'h00, "ch1_disabled");
        check({56'b0, ch_wave[31:24]}, 64'h00, "ch3_disabled");
        check({56'b0, ch_wave[23:16]}, 64'h47, "ch2_enabled");

        // Mixed random traffic, checked by the scoreboard
        for (int i = 0; i < 10; i++) begin
            ch_ptr    = 25'($urandom);
            scc_plus  = 1'($urandom_range(0, 1));
            ch_enable = 5'($urandom);
            cpu_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 200)),
                       8'($urandom), c1);
        end
        tick(14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
